// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: registered multiply or 32-step restoring divide.
// Optional macro DIV_SKIP_EN: a divide with |a| < |b| completes in one cycle.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sgn;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_in_sgn;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic               w_skip;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [2*WIDTH-1:0] w_ma;
    logic [2*WIDTH-1:0] w_mb;
    logic [2*WIDTH-1:0] w_prod;

    // Operand magnitudes at acceptance; op[0]=0 selects the signed variants.
    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_in_sgn = ~op[0];
    assign w_a_mag  = (w_in_sgn && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_in_sgn && b[WIDTH-1]) ? -b : b;
    assign w_b_zero = (b == '0);

`ifdef DIV_SKIP_EN
    assign w_skip = !w_b_zero && (w_a_mag < w_b_mag);
`else
    assign w_skip = 1'b0;
`endif

    // One restoring-divide step; the shifted remainder needs one extra bit.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx  = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_fix = (r_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = (r_sgn && r_a[WIDTH-1]) ? -w_rem_nx : w_rem_nx;

    assign w_ma   = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_mb   = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod = w_ma * w_mb;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!op[1])                 w_next = S_MUL;
                    else if (w_b_zero || w_skip) w_next = S_DONE;
                    else                        w_next = S_DIV;
                end
            end
            S_MUL:   if (r_cnt == '0) w_next = S_DONE;
            S_DIV:   if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // Datapath; a flush freezes everything so HI/LO keep their last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sgn <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sgn <= w_in_sgn;
                        r_a   <= a;
                        r_b   <= b;
                        r_dvs <= w_b_mag;
                        r_quo <= w_a_mag;
                        r_rem <= '0;
                        r_cnt <= op[1] ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
                        if (op[1] && w_b_zero) begin
                            r_hi <= '0;
                            r_lo <= '0;
                        end else if (op[1] && w_skip) begin
                            r_hi <= a;
                            r_lo <= '0;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        r_cnt <= r_cnt - 1'b1;
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == '0) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_o = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_DONE);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage.
- Latches operands, stalls the pipeline while busy, and runs a registered multiply or a 32-step restoring divider.
- Presents the {hi, lo} result with a one-cycle done pulse; the pipeline then writes it into the HI/LO registers.
- Accepts a flush from the exception logic that cancels the operation in flight.

Parameters:
MUL_LAT, 2, cycles spent in MUL state (≥1); models the pipelined multiplier depth
WIDTH, 32, operand width; only 32 is supported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  EX holds a valid mul/div instruction
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  32  rs operand (dividend / multiplicand)
b  input  32  rt operand (divisor / multiplier)
flush  input  1  cancel current op (exception/eret)
stall_o  output  1  freeze IF..EX while high
busy_o  output  1  FSM not in IDLE
done_o  output  1  one-cycle pulse; hi_o/lo_o valid
hi_o  output  32  MULT: product[63:32]; DIV: remainder
lo_o  output  32  MULT: product[31:0]; DIV: quotient

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset: state=IDLE; counter, operand regs, hi_o, lo_o, done_o = 0.
- IDLE, start & !flush: latch a, b and op.
  - op[1]=0 → MUL, cnt=MUL_LAT-1.
  - op[1]=1, b≠0 → DIV, cnt=31.
  - op[1]=1, b==0 → DONE with hi_o=lo_o=0.
- MUL: product = signed 64-bit (MULT) or unsigned (MULTU) from the latched operands. cnt decrements each cycle; at cnt==0 → DONE, loading hi_o/lo_o.
- DIV: the DIV operation takes magnitudes of both operands first; DIVU uses them raw.
  - Each cycle: shift {rem, quo} left 1; if rem ≥ |b|, rem -= |b| and set quo[0]=1. One quotient bit per cycle, MSB first.
  - At cnt==0 → DONE.
  - Sign fix for DIV only: quotient negated if a[31]^b[31]; remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) → lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- DONE: done_o=1 for exactly this cycle; hi_o/lo_o hold until the next result load. → IDLE unconditionally; start is ignored in DONE, since it is still the same instruction.
- stall_o = (IDLE & start & !flush) | MUL | DIV. It is low in DONE, so the instruction advances on the done cycle.
- busy_o = state≠IDLE.
- Latency, start accepted at cycle 0:
  - MULT/MULTU: done_o at cycle MUL_LAT+1.
  - DIV/DIVU: done_o at cycle 33.
  - Divide by zero: done_o at cycle 1.
- flush in any state → IDLE next cycle, no done_o, hi_o/lo_o unchanged. flush has priority over start in IDLE.
- rst mid-operation → IDLE next cycle, all outputs 0.
- Operand changes on a/b after acceptance have no effect.

Optional Feature:
DIV_SKIP_EN:
- Defined: in IDLE, a divide with |a| < |b| (magnitudes per op signedness) and b≠0 goes straight to DONE with lo_o=0, hi_o=a (raw a, sign preserved); done_o at cycle 1.
- Undefined: every nonzero divide takes the full 32 DIV cycles; results are identical either way.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, MUL_LAT=2 → stall_o high cycles 0–2, done_o at cycle 3, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 → done_o at cycle 33, lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); DIVU a=100, b=7 → lo_o=14, hi_o=2.
- DIV b=0 → done_o at cycle 1, hi_o=lo_o=0. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIVU 100/7, flush asserted at cycle 10 → IDLE at cycle 11, no done_o, hi_o/lo_o keep prior values; a new MULTU accepted at cycle 12 completes normally.
- start held high through DONE, then a back-to-back second op → exactly one done_o per instruction. With DIV_SKIP_EN, DIVU 3/7 → done_o at cycle 1, lo_o=0, hi_o=3.
